// File: rtl/ysyx_23060303_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode-side
// instruction handshake, redirect input and halt status.
interface ysyx_23060303_fetch_unit_if #(
  parameter int unsigned PCWIDTH = 32
);
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [PCWIDTH-1:0] mem_addr;
  logic               mem_rsp_valid;
  logic [31:0]        mem_rsp_data;
  logic               inst_valid;
  logic               inst_ready;
  logic [31:0]        inst;
  logic [PCWIDTH-1:0] pc;
  logic               redirect_valid;
  logic [PCWIDTH-1:0] redirect_pc;
  logic               halted;

  // Fetch unit side
  modport master (
    output mem_req_valid, mem_addr, inst_valid, inst, pc, halted,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  mem_req_valid, mem_addr, inst_valid, inst, pc, halted,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060303_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, holds the fetched word
// until decode consumes it, supports redirects with in-flight response kill.
// Optional macro YSYX_23060303_EBREAK_HALT_EN: stop fetching after an ebreak
// word is consumed; only reset leaves the halted state.
module ysyx_23060303_fetch_unit #(
  parameter int unsigned        PCWIDTH  = 32,
  parameter logic [PCWIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_23060303_fetch_unit_if.master   bus
);

`ifdef YSYX_23060303_EBREAK_HALT_EN
  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StHalt} state_e;
  localparam logic [31:0] Ebreak = 32'h0010_0073;
`else
  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold} state_e;
`endif

  state_e             state_q, state_d;
  logic [PCWIDTH-1:0] fpc_q, fpc_d;    // fetch PC (next address to request)
  logic               kill_q, kill_d;  // drop the response still in flight
  logic [31:0]        inst_q, inst_d;
  logic [PCWIDTH-1:0] pc_q, pc_d;
  logic               req_valid;
  logic               inst_valid;
  logic [PCWIDTH-1:0] redir_pc;
  logic               unused_redir_lsb;

  assign redir_pc         = {bus.redirect_pc[PCWIDTH-1:2], 2'b00};
  assign unused_redir_lsb = ^bus.redirect_pc[1:0];

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      fpc_q   <= RESET_PC;
      kill_q  <= 1'b0;
      inst_q  <= 32'h0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    req_valid  = 1'b0;
    inst_valid = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        req_valid = 1'b1;
        if (bus.redirect_valid) fpc_d = redir_pc;
        if (bus.mem_req_ready) begin
          state_d = StWait;
          // Request already accepted for the old path: its response is stale
          kill_d  = bus.redirect_valid;
        end
      end
      StWait: begin
        if (bus.redirect_valid) fpc_d = redir_pc;
        if (bus.mem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || bus.redirect_valid) begin
            state_d = StReq;
          end else begin
            inst_d  = bus.mem_rsp_data;
            pc_d    = fpc_q;
            state_d = StHold;
          end
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      StHold: begin
        inst_valid = 1'b1;
        // Redirect takes priority over a simultaneous consume
        if (bus.redirect_valid) begin
          fpc_d   = redir_pc;
          state_d = StReq;
        end else if (bus.inst_ready) begin
`ifdef YSYX_23060303_EBREAK_HALT_EN
          if (inst_q == Ebreak) begin
            state_d = StHalt;
          end else begin
            fpc_d   = fpc_q + PCWIDTH'(4);
            state_d = StReq;
          end
`else
          fpc_d   = fpc_q + PCWIDTH'(4);
          state_d = StReq;
`endif
        end
      end
`ifdef YSYX_23060303_EBREAK_HALT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StIdle;
    endcase
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_addr      = {fpc_q[PCWIDTH-1:2], 2'b00};
  assign bus.inst_valid    = inst_valid;
  assign bus.inst          = inst_q;
  assign bus.pc            = pc_q;
`ifdef YSYX_23060303_EBREAK_HALT_EN
  assign bus.halted        = (state_q == StHalt);
`else
  assign bus.halted        = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060303_fetch_unit.sv
// Directed testbench for ysyx_23060303_fetch_unit. Inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_ysyx_23060303_fetch_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ysyx_23060303_fetch_unit_if #(.PCWIDTH(32)) bus ();

  ysyx_23060303_fetch_unit #(
    .PCWIDTH (32),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In REQ: check request, accept it (one cycle)
  task automatic do_req(input string tag, input logic [31:0] addr);
    check({tag, ".req_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check({tag, ".addr"}, 64'(bus.mem_addr), 64'(addr));
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
  endtask

  // In WAIT: return a response (one cycle)
  task automatic do_rsp(input logic [31:0] data);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = data;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'hDEAD_BEEF;
  endtask

  // In HOLD: check presented instruction, consume it
  task automatic do_hold(input string tag, input logic [31:0] word, input logic [31:0] addr);
    check({tag, ".inst_valid"}, 64'(bus.inst_valid), 64'd1);
    check({tag, ".inst"}, 64'(bus.inst), 64'(word));
    check({tag, ".pc"}, 64'(bus.pc), 64'(addr));
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    tick();
    tick();

    // Reset state
    check("rst.req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst.inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst.halted", 64'(bus.halted), 64'd0);
    check("rst.pc", 64'(bus.pc), 64'h8000_0000);
    check("rst.inst", 64'(bus.inst), 64'h0);

    // First cycle after release is IDLE, request appears in the second
    rst = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    check("idle.req_valid", 64'(bus.mem_req_valid), 64'd1);

    // Straight-line fetch, zero-wait memory
    do_req("f0", 32'h8000_0000);
    check("f0.wait_inst_valid", 64'(bus.inst_valid), 64'd0);
    do_rsp(32'h0000_0013);
    do_hold("f0", 32'h0000_0013, 32'h8000_0000);
    do_req("f1", 32'h8000_0004);
    do_rsp(32'h0010_0093);
    do_hold("f1", 32'h0010_0093, 32'h8000_0004);
    do_req("f2", 32'h8000_0008);
    do_rsp(32'h0020_0113);
    do_hold("f2", 32'h0020_0113, 32'h8000_0008);

    // Stall in HOLD for 5 cycles; stray responses must be ignored
    do_req("st", 32'h8000_000C);
    do_rsp(32'h0030_0193);
    for (int i = 0; i < 5; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h1111_1111;
      tick();
      bus.mem_rsp_valid = 1'b0;
      check("stall.inst_valid", 64'(bus.inst_valid), 64'd1);
      check("stall.inst", 64'(bus.inst), 64'h0030_0193);
      check("stall.pc", 64'(bus.pc), 64'h8000_000C);
      check("stall.req_valid", 64'(bus.mem_req_valid), 64'd0);
    end
    do_hold("st", 32'h0030_0193, 32'h8000_000C);
    check("st.next_addr", 64'(bus.mem_addr), 64'h8000_0010);

    // Redirect while in WAIT: response killed, low bits of target cleared
    do_req("rw", 32'h8000_0010);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0103;
    tick();
    bus.redirect_valid = 1'b0;
    check("rw.wait_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rw.wait_req_valid", 64'(bus.mem_req_valid), 64'd0);
    do_rsp(32'h2222_2222);
    check("rw.killed_inst_valid", 64'(bus.inst_valid), 64'd0);
    do_req("rw2", 32'h8000_0100);
    do_rsp(32'h0040_0213);
    do_hold("rw2", 32'h0040_0213, 32'h8000_0100);

    // Redirect in REQ without ready: stay REQ, address moves next cycle
    check("rr.addr_before", 64'(bus.mem_addr), 64'h8000_0104);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    tick();
    bus.redirect_valid = 1'b0;
    check("rr.req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("rr.addr", 64'(bus.mem_addr), 64'h8000_0200);

    // Redirect with accept, then a second redirect coinciding with the killed rsp
    bus.mem_req_ready  = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0300;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.redirect_pc    = 32'h8000_0400;
    bus.mem_rsp_valid  = 1'b1;
    bus.mem_rsp_data   = 32'h3333_3333;
    tick();
    bus.redirect_valid = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    check("ra.inst_valid", 64'(bus.inst_valid), 64'd0);
    check("ra.req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("ra.addr", 64'(bus.mem_addr), 64'h8000_0400);

    // Redirect and inst_ready together in HOLD: redirect wins
    do_req("rh", 32'h8000_0400);
    do_rsp(32'h0050_0293);
    check("rh.inst_valid", 64'(bus.inst_valid), 64'd1);
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0500;
    tick();
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    check("rh.inst_valid_after", 64'(bus.inst_valid), 64'd0);
    check("rh.addr", 64'(bus.mem_addr), 64'h8000_0500);
    check("rh.pc_held", 64'(bus.pc), 64'h8000_0400);

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    do_req("wr", 32'hFFFF_FFFC);
    do_rsp(32'h0060_0313);
    do_hold("wr", 32'h0060_0313, 32'hFFFF_FFFC);
    check("wr.addr", 64'(bus.mem_addr), 64'h0);

    // ebreak word
    do_req("eb", 32'h0000_0000);
    do_rsp(32'h0010_0073);
    do_hold("eb", 32'h0010_0073, 32'h0000_0000);
`ifdef YSYX_23060303_EBREAK_HALT_EN
    check("eb.halted", 64'(bus.halted), 64'd1);
    check("eb.req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("eb.inst_valid", 64'(bus.inst_valid), 64'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0800;
    bus.mem_req_ready  = 1'b1;
    tick();
    tick();
    bus.redirect_valid = 1'b0;
    bus.mem_req_ready  = 1'b0;
    check("eb.halted_hold", 64'(bus.halted), 64'd1);
    check("eb.req_valid_hold", 64'(bus.mem_req_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("eb.halted_rst", 64'(bus.halted), 64'd0);
    tick();
    do_req("eb_restart", 32'h8000_0000);
    do_rsp(32'h0070_0393);
    do_hold("eb_restart", 32'h0070_0393, 32'h8000_0000);
`else
    check("eb.halted", 64'(bus.halted), 64'd0);
    check("eb.req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("eb.addr", 64'(bus.mem_addr), 64'h0000_0004);
`endif

    // Reset mid-transaction; late response in IDLE/REQ ignored
    do_req("mr", bus.mem_addr);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h4444_4444;
    tick();
    check("mr.idle_inst_valid", 64'(bus.inst_valid), 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    check("mr.req_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("mr.inst", 64'(bus.inst), 64'h0);
    do_req("mr2", 32'h8000_0000);
    do_rsp(32'h0080_0413);
    do_hold("mr2", 32'h0080_0413, 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
